// File: rtl/final_permutation_block.sv
// DES final permutation (IP^-1) with a 1-cycle registered output.
// Optional FINAL_PERM_INVERSE_EN adds an `inverse` port that selects the initial permutation IP.
module final_permutation_block (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [63:0] in,
`ifdef FINAL_PERM_INVERSE_EN
  input  logic        inverse,
`endif
  output logic        out_valid,
  output logic [63:0] out
);

  // Entry k is the source DES bit for output DES bit k+1; DES bit n is vector bit [64-n].
  localparam int unsigned FP_TAB [64] = '{
    40, 8, 48, 16, 56, 24, 64, 32,
    39, 7, 47, 15, 55, 23, 63, 31,
    38, 6, 46, 14, 54, 22, 62, 30,
    37, 5, 45, 13, 53, 21, 61, 29,
    36, 4, 44, 12, 52, 20, 60, 28,
    35, 3, 43, 11, 51, 19, 59, 27,
    34, 2, 42, 10, 50, 18, 58, 26,
    33, 1, 41,  9, 49, 17, 57, 25
  };

  logic [63:0] fp_w;
  logic [63:0] perm_w;

  for (genvar i = 0; i < 64; i++) begin : g_fp
    localparam int unsigned SRC = 64 - FP_TAB[i];
    assign fp_w[63-i] = in[SRC];
  end

`ifdef FINAL_PERM_INVERSE_EN
  localparam int unsigned IP_TAB [64] = '{
    58, 50, 42, 34, 26, 18, 10, 2,
    60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6,
    64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17,  9, 1,
    59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5,
    63, 55, 47, 39, 31, 23, 15, 7
  };

  logic [63:0] ip_w;

  for (genvar i = 0; i < 64; i++) begin : g_ip
    localparam int unsigned SRC = 64 - IP_TAB[i];
    assign ip_w[63-i] = in[SRC];
  end

  assign perm_w = inverse ? ip_w : fp_w;
`else
  assign perm_w = fp_w;
`endif

  // Reset wins over in_valid; out only loads on an accepted block.
  always_ff @(posedge clk) begin
    if (rst) begin
      out       <= 64'h0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) out <= perm_w;
    end
  end

endmodule

// File: tb/tb_final_permutation_block.sv
// Self-checking bench for final_permutation_block; reference permutations are
// generated from the row/column structure of the DES IP and FP tables.
module tb_final_permutation_block;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [63:0] in;
  logic        inverse;
  logic        out_valid;
  logic [63:0] out;

  int checks = 0;
  int errors = 0;

  logic [63:0] exp_out;
  logic        exp_vld;

  final_permutation_block dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in        (in),
`ifdef FINAL_PERM_INVERSE_EN
    .inverse   (inverse),
`endif
    .out_valid (out_valid),
    .out       (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // FP row r, column c: even columns start at 40, odd at 8, stepping +8 per column pair, -1 per row.
  function automatic int fp_src(input int i);
    int r, c;
    r = (i - 1) / 8;
    c = (i - 1) % 8;
    return ((c % 2 == 0) ? 40 : 8) + 8 * (c / 2) - r;
  endfunction

  // IP row r: rows 0..3 start at 58,60,62,64, rows 4..7 at 57,59,61,63, then -8 per column.
  function automatic int ip_src(input int i);
    int r, c;
    r = (i - 1) / 8;
    c = (i - 1) % 8;
    return ((r < 4) ? (58 + 2 * r) : (57 + 2 * (r - 4))) - 8 * c;
  endfunction

  function automatic logic [63:0] model(input logic [63:0] d, input logic inv);
    logic [63:0] r;
    r = '0;
    for (int i = 1; i <= 64; i++)
      r[64-i] = d[64 - (inv ? ip_src(i) : fp_src(i))];
    return r;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Apply one cycle of inputs, advance the model, and compare after the edge.
  task automatic cyc(input logic r, input logic v, input logic [63:0] d, input logic inv);
    rst = r; in_valid = v; in = d; inverse = inv;
    @(posedge clk);
    if (r) begin
      exp_out = '0;
      exp_vld = 1'b0;
    end else begin
      exp_vld = v;
      if (v) exp_out = model(d, inv);
    end
    #1;
    check("out", out, exp_out);
    check("out_valid", {63'b0, out_valid}, {63'b0, exp_vld});
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  initial begin
    logic [63:0] seen;
    logic [63:0] held;
    logic [63:0] one;
    exp_out = '0;
    exp_vld = 1'b0;
    rst = 1'b1; in_valid = 1'b1; in = '1; inverse = 1'b0;

    // Reset beats a valid all-ones block
    cyc(1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    check("reset_out", out, 64'h0);
    check("reset_vld", {63'b0, out_valid}, 64'h0);

    // First post-reset edge accepts the known vector
    cyc(1'b0, 1'b1, 64'hCC00_CCFF_F0AA_F0AA, 1'b0);
    check("known_vec", out, 64'h0123_4567_89AB_CDEF);
    cyc(1'b0, 1'b1, 64'h0, 1'b0);
    check("all_zero", out, 64'h0);
    cyc(1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    check("all_one", out, 64'hFFFF_FFFF_FFFF_FFFF);

    // One-hot sweep: every output one-hot and all positions distinct
    seen = '0;
    one  = 64'h1;
    for (int k = 0; k < 64; k++) begin
      cyc(1'b0, 1'b1, one << k, 1'b0);
      check("onehot_pop", 64'($countones(out)), 64'd1);
      if (k == 0)  check("onehot_lsb", out, 64'h0200_0000_0000_0000);
      if (k == 63) check("onehot_msb", out, 64'h0000_0000_0000_0040);
      seen = seen | out;
    end
    check("onehot_distinct", seen, 64'hFFFF_FFFF_FFFF_FFFF);

    // Hold: output frozen while in_valid is low and in wanders
    cyc(1'b0, 1'b1, rnd64(), 1'b0);
    held = exp_out;
    for (int k = 0; k < 5; k++) begin
      cyc(1'b0, 1'b0, rnd64(), 1'b0);
      check("hold_out", out, held);
    end

    // Throughput: 8 back-to-back random blocks, plus popcount preservation
    for (int k = 0; k < 8; k++) begin
      logic [63:0] d;
      d = rnd64();
      cyc(1'b0, 1'b1, d, 1'b0);
      check("popcount", 64'($countones(out)), 64'($countones(d)));
    end

    // Reset mid-stream drops the block, next edge accepts normally
    cyc(1'b1, 1'b1, rnd64(), 1'b0);
    cyc(1'b0, 1'b1, rnd64(), 1'b0);

    // Random mix of valid/idle/reset
    for (int k = 0; k < 60; k++)
      cyc(($urandom_range(0, 15) == 0), $urandom_range(0, 1) == 1, rnd64(), 1'b0);

`ifdef FINAL_PERM_INVERSE_EN
    cyc(1'b0, 1'b1, 64'h0123_4567_89AB_CDEF, 1'b1);
    check("ip_known", out, 64'hCC00_CCFF_F0AA_F0AA);
    held = out;
    cyc(1'b0, 1'b1, held, 1'b0);
    check("ip_roundtrip", out, 64'h0123_4567_89AB_CDEF);
    for (int k = 0; k < 20; k++)
      cyc(1'b0, $urandom_range(0, 3) != 0, rnd64(), $urandom_range(0, 1) == 1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
